flag_update_arbiter: RTL
========================

# flag_update_arbiter

Shares the processor's condition-flag bank (NFLAGS one-bit flag registers) between NREQ writers (ALU, shifter, interrupt/CSR path). Each cycle it picks at most one pending requester, commits that requester's masked flag update into the bank, and returns a one-cycle grant pulse. It sits between the execute-stage producers and the branch unit, which reads `Flags` directly.

## Interface
- `NREQ`, 3: number of requesters; legal range 2..8.
- `NFLAGS`, 4: number of flag bits; bit 0 = Z, 1 = N, 2 = C, 3 = V for the default.

- `CLK` in 1: clock, all state updates on rising edge.
- `Reset` in 1: reset, synchronous, active-high.
- `Hold` in 1: pipeline stall; when high, no commit and no grant occur.
- `Req` in NREQ: request per requester, level; held until granted.
- `ReqMask` in NREQ*NFLAGS: slice i = bits [i*NFLAGS +: NFLAGS], 1 = update that flag.
- `ReqData` in NREQ*NFLAGS: slice i = new flag values, same packing.
- `Grant` out NREQ: registered one-hot pulse; bit i high for exactly one cycle after requester i's update committed.
- `Flags` out NFLAGS: current flag bank, registered.
- `Busy` out 1: registered; high when ≥1 eligible request was left waiting at the last edge.

## Operation
- Eligibility at an edge: `Req[i]`=1 AND `Grant[i]`=0 (current value). A requester just granted is never re-granted on the next edge, so it has one full cycle to drop or change `Req`.
- If `Reset`: `Flags`=0, `Grant`=0, `Busy`=0, priority pointer `Ptr`=0. Reset wins over `Hold` and all requests. A reset mid-request discards that request; no grant is issued for it.
- Else if `Hold`: `Flags`, `Ptr` unchanged; `Grant`<=0; `Busy`<=1 if any requester is eligible, else 0.
- Else if no requester eligible: `Grant`<=0, `Busy`<=0, all else unchanged.
- Else winner W selected (see Configuration), then:
  - `Flags` <= (`Flags` & ~`ReqMask[W]`) | (`ReqData[W]` & `ReqMask[W]`).
  - `Grant` <= one-hot(W).
  - `Busy` <= 1 if any other requester is eligible, else 0.
  - `Ptr` <= (W+1) mod NREQ; wraps NREQ-1 → 0.
- A request with mask all-zero is still arbitrated and granted; `Flags` are unchanged.
- Bits of `ReqData` outside the mask are ignored.
- Requester protocol: hold `Req`, `ReqMask`, `ReqData` stable until `Grant[i]` is seen high. In the `Grant` cycle, either drop `Req` or present the next update. The new update is eligible at the following edge.
- Exactly one flag write occurs per edge at most. There is no merging of updates from different requesters.

## Timing
- Request-to-commit latency is 1 edge when uncontended and not held. `Req` high before edge k gives `Flags` updated and `Grant` high in cycle k+1.
- Under contention, worst-case wait with round-robin is NREQ-1 grants plus held cycles.
- `Flags` and `Grant` change on the same edge. A consumer sampling `Flags` in the `Grant` cycle sees the committed value.
- `Grant` is never high for two consecutive cycles for the same bit. At most one `Grant` bit is high at a time.
- Every output is registered. There is no combinational path from inputs to outputs.

## Configuration
- `FLAG_ARB_ROUND_ROBIN_EN` defined: W is the first eligible index found searching from `Ptr` upward, wrapping modulo NREQ. `Ptr` is updated as above.
- Not defined: fixed priority, where W is the lowest eligible index. `Ptr` logic is omitted and its value is irrelevant.
- All other behaviour is identical in both builds.

## Test plan
- Reset with `Flags` previously at 4'b1111 and `Req`=3'b111 → the cycle after the `Reset` edge shows `Flags`=0, `Grant`=0, `Busy`=0.
- Single request: `Req`=3'b010, `ReqMask[1]`=4'b0011, `ReqData[1]`=4'b1101, `Flags`=4'b1000 → next cycle `Flags`=4'b1001, `Grant`=3'b010.
- Contention, round-robin build: `Req`=3'b111 held continuously → `Grant` sequence 001, 010, 100, 001. `Busy`=1 throughout. No bit is high two cycles in a row.
- Contention, fixed-priority build: `Req`=3'b011 held → `Grant` alternates 001, 010, 001. Requester 2 is never granted while requester 0 keeps requesting.
- `Hold`=1 for 3 cycles with `Req`=3'b100 → `Grant`=0, `Flags` unchanged, `Busy`=1. The first edge after `Hold` falls gives `Grant`=3'b100 and `Flags` updated.
- Zero mask: `Req`=3'b001, `ReqMask[0]`=0, `ReqData[0]`=4'b1111 → `Grant`=3'b001 and `Flags` unchanged. Also assert `Reset` while `Req` is pending → no `Grant` is ever issued for that request.

Source files
------------

// File: rtl/flag_update_arbiter.sv
// Purpose : arbitrates masked updates from NREQ producers into one shared NFLAGS-bit condition-flag bank.
// Latency : 1 edge from an eligible Req to the committed Flags and the Grant pulse.
// Backpress: a requester is stalled while Hold is high or another requester wins. It holds Req/ReqMask/ReqData until it sees Grant.
//
// Ports:
//   CLK, Reset      - rising-edge clock; synchronous active-high reset
//   Hold            - pipeline stall: no commit, no grant
//   Req[NREQ]       - level request per requester
//   ReqMask/ReqData - per-requester flag mask/value, slice i at [i*NFLAGS +: NFLAGS]
//   Grant[NREQ]     - registered one-hot pulse, one cycle after the commit edge
//   Flags[NFLAGS]   - registered flag bank
//   Busy            - registered; an eligible request was left waiting at the last edge
//
// Build option: define FLAG_ARB_ROUND_ROBIN_EN for round-robin arbitration.
// The default build uses fixed priority, where the lowest index wins.
module flag_update_arbiter #(
    parameter int NREQ   = 3,
    parameter int NFLAGS = 4
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     Hold,
    input  logic [NREQ-1:0]          Req,
    input  logic [NREQ*NFLAGS-1:0]   ReqMask,
    input  logic [NREQ*NFLAGS-1:0]   ReqData,
    output logic [NREQ-1:0]          Grant,
    output logic [NFLAGS-1:0]        Flags,
    output logic                     Busy
);

    logic [NFLAGS-1:0] flags_q, flags_d;
    logic [NREQ-1:0]   grant_q;
    logic              busy_q;

    logic [NREQ-1:0]   elig;
    logic [NREQ-1:0]   win_oh;
    logic              found;
    logic [NFLAGS-1:0] sel_mask;
    logic [NFLAGS-1:0] sel_data;

    // A requester granted at the last edge sits out one edge.
    // This gives it a full cycle to drop Req or to present its next update.
    assign elig = Req & ~grant_q;

`ifdef FLAG_ARB_ROUND_ROBIN_EN
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] win_idx;

    // The winner is the eligible index with the smallest distance from ptr_q, measured upward with wrap.
    // The distance is computed per index so that every bit select uses a constant index.
    always_comb begin
        int best_d;
        int d;
        found   = 1'b0;
        win_oh  = '0;
        win_idx = '0;
        best_d  = NREQ;
        d       = 0;
        for (int i = 0; i < NREQ; i++) begin
            d = i - int'(ptr_q);
            if (d < 0) begin
                d = d + NREQ;
            end
            if (elig[i] && (d < best_d)) begin
                best_d    = d;
                found     = 1'b1;
                win_oh    = '0;
                win_oh[i] = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
    end
`else
    // Fixed priority: the lowest eligible index wins.
    always_comb begin
        found  = 1'b0;
        win_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (elig[i] && !found) begin
                found     = 1'b1;
                win_oh[i] = 1'b1;
            end
        end
    end
`endif

    // Select the winner's slice. win_oh is one-hot or zero, so an OR-mux is enough.
    always_comb begin
        sel_mask = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                sel_mask = sel_mask | ReqMask[i*NFLAGS +: NFLAGS];
                sel_data = sel_data | ReqData[i*NFLAGS +: NFLAGS];
            end
        end
        flags_d = (flags_q & ~sel_mask) | (sel_data & sel_mask);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            flags_q <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
`ifdef FLAG_ARB_ROUND_ROBIN_EN
            ptr_q   <= '0;
`endif
        end else if (Hold) begin
            grant_q <= '0;
            busy_q  <= |elig;
        end else if (!found) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            flags_q <= flags_d;
            grant_q <= win_oh;
            busy_q  <= |(elig & ~win_oh);
`ifdef FLAG_ARB_ROUND_ROBIN_EN
            ptr_q   <= (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
`endif
        end
    end

    assign Grant = grant_q;
    assign Flags = flags_q;
    assign Busy  = busy_q;

endmodule
